param_data_memory: RTL and testbench

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

---
 rtl/param_data_memory.sv | 133 +++++++++++++
 tb/tb_param_data_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_data_memory.sv
// Byte-addressable little-endian data memory with configurable depth and a fully
// pipelined load path that returns extended results a fixed number of cycles after the request.
module param_data_memory #(
  parameter int DEPTH_LOG2   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic                  req;
  logic                  fault;
  logic                  out_of_range;
  logic                  do_store;
  logic                  do_load;
  logic                  do_fault;
  logic [3:0]            byte_en;
  logic [31:0]           store_word;

  logic                  vld_p  [READ_LATENCY];
  logic                  err_p  [READ_LATENCY];
  logic [31:0]           data_p [READ_LATENCY];

  // Select the addressed byte or half of a word, right-justify and extend it.
  function automatic logic [31:0] extend_load(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  ln,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ln +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    extend_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    extend_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extend_load = w;
    endcase
  endfunction

  assign word_idx     = address[DEPTH_LOG2+1:2];
  assign lane         = address[1:0];
  assign out_of_range = (address >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign req          = mem_read | mem_write;

  always_comb begin
    fault = 1'b0;
    if (mem_read && mem_write)            fault = 1'b1;
    if (size == 2'b11)                    fault = 1'b1;
    if (size == SZ_H && address[0])       fault = 1'b1;
    if (size == SZ_W && lane != 2'b00)    fault = 1'b1;
    if (out_of_range)                     fault = 1'b1;
  end

  // Requests on a reset edge are discarded entirely.
  assign do_store = rst_n & mem_write & ~fault;
  assign do_load  = mem_read & ~fault;
  assign do_fault = req & fault;

  always_comb begin
    byte_en    = 4'b0000;
    store_word = write_data;
    case (size)
      SZ_B: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{write_data[7:0]}};
      end
      SZ_H: begin
        byte_en    = address[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
      end
      SZ_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // Storage: not reset, byte-lane write enables.
  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  // Stage 0 reads the array on the request edge; later stages are pure delay.
  // Data registers only advance with a live slot so the last one holds read_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_p[i] <= 1'b0;
        err_p[i] <= 1'b0;
      end
      data_p[READ_LATENCY-1] <= '0;
    end else begin
      vld_p[0] <= do_load;
      err_p[0] <= do_fault;
      if (do_load || do_fault) begin
        data_p[0] <= do_fault ? 32'd0
                              : extend_load(mem[word_idx], size, lane, unsigned_ld);
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        err_p[i] <= err_p[i-1];
        if (vld_p[i-1] || err_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign read_valid = vld_p[READ_LATENCY-1];
  assign error      = err_p[READ_LATENCY-1];
  assign read_data  = data_p[READ_LATENCY-1];

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench: two instances (latency 1 and 3) share one stimulus stream and
// are checked against a word-array reference model of the memory.
module tb_param_data_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;

  logic [31:0] rd1, rd3;
  logic        v1, v3, e1, e3;

  always #5 clk = ~clk;

  param_data_memory #(.DEPTH_LOG2(8), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .unsigned_ld(unsigned_ld), .address(address),
    .write_data(write_data), .read_data(rd1), .read_valid(v1), .error(e1)
  );

  param_data_memory #(.DEPTH_LOG2(8), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .unsigned_ld(unsigned_ld), .address(address),
    .write_data(write_data), .read_data(rd3), .read_valid(v3), .error(e3)
  );

  typedef struct {
    int          req_edge;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        q1[$];
  exp_t        q3[$];
  logic [31:0] mem_m [256];
  int          edge_cnt = 0;
  logic        rst_last = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last1 = 32'd0;
  logic [31:0] last3 = 32'd0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_last <= rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input int sz,
                                             input int ln, input bit uns);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * ln)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (8 * ln)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Compare one instance's outputs at the falling edge after edge edge_cnt.
  task automatic monitor(input int k, input int lat, input logic v, input logic e,
                         input logic [31:0] d);
    exp_t        f;
    logic        ev, ee;
    logic [31:0] ed, last;
    int          qn;
    last = (k == 1) ? last1 : last3;
    if (!rst_last) begin
      check($sformatf("reset_flags_L%0d", lat), {30'd0, v, e}, 32'd0);
      check($sformatf("reset_data_L%0d", lat), d, 32'd0);
      last = 32'd0;
    end else begin
      ev = 1'b0;
      ee = 1'b0;
      ed = last;
      qn = (k == 1) ? q1.size() : q3.size();
      while (qn > 0) begin
        f = (k == 1) ? q1[0] : q3[0];
        if (f.req_edge + lat - 1 > edge_cnt) break;
        if (k == 1) void'(q1.pop_front()); else void'(q3.pop_front());
        qn--;
        if (f.req_edge + lat - 1 < edge_cnt) begin
          check($sformatf("missed_resp_L%0d", lat), 32'(edge_cnt), 32'(f.req_edge + lat - 1));
        end else begin
          ev = !f.err;
          ee = f.err;
          ed = f.err ? 32'd0 : f.data;
        end
      end
      check($sformatf("valid_error_L%0d", lat), {30'd0, v, e}, {30'd0, ev, ee});
      check($sformatf("read_data_L%0d", lat), d, ed);
      last = ed;
    end
    if (k == 1) last1 = last; else last3 = last;
  endtask

  always @(negedge clk) begin
    monitor(1, 1, v1, e1, rd1);
    monitor(3, 3, v3, e3, rd3);
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    exp_t        x;
    bit          flt;
    int          idx, ln, s;
    logic [31:0] mask;
    @(negedge clk);
    #1;
    rst_n       = 1'b1;
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    unsigned_ld = uns;
    address     = a;
    write_data  = wd;
    x.req_edge  = edge_cnt + 1;
    if (rd || wr) begin
      s   = int'(sz);
      flt = (rd && wr) || (s == 3) || (s == 1 && a[0]) || (s == 2 && a[1:0] != 2'b00)
            || (a >= 32'h400);
      idx = int'(a[9:2]);
      ln  = int'(a[1:0]);
      if (flt) begin
        x.err  = 1'b1;
        x.data = 32'd0;
        q1.push_back(x);
        q3.push_back(x);
      end else if (wr) begin
        mask = (s == 0) ? 32'hFF : (s == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mem_m[idx] = (mem_m[idx] & ~(mask << (8 * ln))) | ((wd & mask) << (8 * ln));
      end else begin
        x.err  = 1'b0;
        x.data = model_load(mem_m[idx], s, ln, uns);
        q1.push_back(x);
        q3.push_back(x);
      end
    end
  endtask

  // Hold reset for n edges; optionally present a store that must be ignored.
  task automatic do_reset(input int n, input bit junk);
    int r;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      #1;
      rst_n       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = junk;
      size        = 2'b10;
      address     = 32'($urandom_range(0, 15)) << 2;
      write_data  = $urandom;
      r = edge_cnt + 1;
      while (q1.size() > 0 && q1[$].req_edge >= r) void'(q1.pop_back());
      while (q3.size() > 0 && q3[$].req_edge + 2 >= r) void'(q3.pop_back());
    end
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    logic [1:0]  sz;
    do_reset(3, 1'b0);

    for (int i = 0; i < 256; i++) drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

    // Word store/load, byte and half extraction, byte merge.
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'd0);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Faulted requests, then confirm memory untouched.
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h1234_5678);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0);

    // Four back-to-back loads through the pipeline.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 2'b10, 1'b0, 32'(i * 4), 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    // Load in flight across a one-cycle reset, then re-read the same word.
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    do_reset(1, 1'b1);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 99));
      sz = 2'($urandom_range(0, 2));
      a  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 19) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 29) == 0) sz = 2'b11;
      if ($urandom_range(0, 29) == 0) a = a | (32'd1 << $urandom_range(10, 31));
      if (r < 40)      drive(1'b1, 1'b0, sz, 1'($urandom_range(0, 1)), a, $urandom);
      else if (r < 75) drive(1'b0, 1'b1, sz, 1'b0, a, $urandom);
      else if (r < 88) drive(1'b0, 1'b0, sz, 1'b0, a, $urandom);
      else if (r < 91) drive(1'b1, 1'b1, sz, 1'b0, a, $urandom);
      else if (r < 99) drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b0, a, 32'd0);
      else             do_reset(int'($urandom_range(1, 2)), 1'b1);
    end

    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    check("drain_L1", 32'(q1.size()), 32'd0);
    check("drain_L3", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
